// File: rtl/cfg_loader.sv
// cfg_loader: serializes one config-chain frame per command.
// Frame = target ID (MSB first) + cmd_len payload bits (LSB first),
// then GAP_CYCLES idle cycles with the chain outputs low.
// Ports:
//   cmd_valid/cmd_ready/cmd_id/cmd_len  command handshake
//   dat_valid/dat_ready/dat             payload word handshake
//   cfg_out_start/cfg_bit_out           registered chain outputs
//   busy, done, err_underrun, err_len   status
// Optional: define CFG_LOADER_PARITY_EN to append a parity bit.
module cfg_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  crst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  dat_valid,
  output logic                  dat_ready,
  input  logic [WORD_WIDTH-1:0] dat,
  output logic                  cfg_out_start,
  output logic                  cfg_bit_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underrun,
  output logic                  err_len
);

  localparam int WIW =
    (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int HIW =
    (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam int GIW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
`ifdef CFG_LOADER_PARITY_EN
    PAR,
`endif
    GAP
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [HIW-1:0]        hdr_idx;
  logic [LEN_WIDTH-1:0]  bit_cnt;
  logic [LEN_WIDTH-1:0]  words_left;
  logic [LEN_WIDTH-1:0]  words_need;
  logic [LEN_WIDTH:0]    len_round;
  logic [WIW-1:0]        widx;
  logic [GIW-1:0]        gap_cnt;
  logic [WORD_WIDTH-1:0] mem [2];
  logic                  wp;
  logic                  rp;
  logic [1:0]            cnt;
  logic                  cmd_fire;
  logic                  push;
  logic                  pop;
  logic                  emit;
  logic                  head_ok;
  logic                  pay_bit;
  logic                  slot_end;
`ifdef CFG_LOADER_PARITY_EN
  logic                  par;
`endif

  // emit: the next cycle shows a payload bit.
  // A missing head word yields a zero bit.
  always_comb begin
    cmd_fire  = cmd_valid & cmd_ready;
    head_ok   = cnt != 2'd0;
    pay_bit   = head_ok & mem[rp][widx];
    slot_end  = widx == WIW'(WORD_WIDTH - 1);
    emit      = (state == HDR && hdr_idx == '0)
             || (state == PAY
                 && bit_cnt != LEN_WIDTH'(1));
    pop       = emit & slot_end & head_ok;
    push      = dat_valid & dat_ready;
    len_round = {1'b0, cmd_len}
              + (LEN_WIDTH+1)'(WORD_WIDTH - 1);
    words_need = LEN_WIDTH'(len_round
               / (LEN_WIDTH+1)'(WORD_WIDTH));
  end

  assign busy = state != IDLE;
  assign dat_ready = (state == HDR || state == PAY)
                  && cnt != 2'd2
                  && words_left != '0;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= dat;
  end

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= 2'd0;
      words_left <= '0;
    end else if (cmd_fire) begin
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= 2'd0;
      words_left <= words_need;
    end else begin
      if (push) begin
        wp         <= ~wp;
        words_left <= words_left - LEN_WIDTH'(1);
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge crst) begin
    if (crst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      cfg_out_start <= 1'b0;
      cfg_bit_out   <= 1'b0;
      done          <= 1'b0;
      err_underrun  <= 1'b0;
      err_len       <= 1'b0;
      id_q          <= '0;
      hdr_idx       <= '0;
      bit_cnt       <= '0;
      widx          <= '0;
      gap_cnt       <= '0;
`ifdef CFG_LOADER_PARITY_EN
      par           <= 1'b0;
`endif
    end else begin
      cfg_out_start <= 1'b0;
      done          <= 1'b0;
      err_len       <= 1'b0;
      if (emit) begin
        cfg_bit_out <= pay_bit;
`ifdef CFG_LOADER_PARITY_EN
        par         <= par ^ pay_bit;
`endif
        if (!head_ok) err_underrun <= 1'b1;
        widx <= slot_end ? '0 : widx + WIW'(1);
      end
      unique case (state)
        IDLE: begin
          cmd_ready   <= 1'b1;
          cfg_bit_out <= 1'b0;
          if (cmd_fire) begin
            err_underrun <= 1'b0;
            id_q         <= cmd_id;
            bit_cnt      <= cmd_len;
            widx         <= '0;
`ifdef CFG_LOADER_PARITY_EN
            par          <= 1'b0;
`endif
            if (cmd_len == '0) begin
              err_len <= 1'b1;
            end else begin
              state         <= HDR;
              cmd_ready     <= 1'b0;
              cfg_out_start <= 1'b1;
              cfg_bit_out   <= cmd_id[ID_WIDTH-1];
              hdr_idx       <= HIW'(ID_WIDTH - 1);
            end
          end
        end
        HDR: begin
          if (hdr_idx != '0) begin
            hdr_idx     <= hdr_idx - HIW'(1);
            cfg_bit_out <= id_q[hdr_idx - HIW'(1)];
          end else begin
            state <= PAY;
          end
        end
        PAY: begin
          if (bit_cnt == LEN_WIDTH'(1)) begin
`ifdef CFG_LOADER_PARITY_EN
            state       <= PAR;
            cfg_bit_out <= par;
`else
            state       <= GAP;
            cfg_bit_out <= 1'b0;
            gap_cnt     <= GIW'(GAP_CYCLES - 1);
            done        <= GAP_CYCLES == 1;
`endif
          end else begin
            bit_cnt <= bit_cnt - LEN_WIDTH'(1);
          end
        end
`ifdef CFG_LOADER_PARITY_EN
        PAR: begin
          state       <= GAP;
          cfg_bit_out <= 1'b0;
          gap_cnt     <= GIW'(GAP_CYCLES - 1);
          done        <= GAP_CYCLES == 1;
        end
`endif
        GAP: begin
          cfg_bit_out <= 1'b0;
          if (gap_cnt == '0) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GIW'(1);
            done    <= gap_cnt == GIW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: self-checking bench for cfg_loader.
// Vector table, hand sequences and randomized frames vs a queue model.
module tb_cfg_loader;

  localparam int W   = 32;
  localparam int ID  = 3;
  localparam int GAP = 2;
`ifdef CFG_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          crst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [ID-1:0] cmd_id;
  logic [15:0]   cmd_len;
  logic          dat_valid;
  logic          dat_ready;
  logic [W-1:0]  dat;
  logic          cfg_out_start;
  logic          cfg_bit_out;
  logic          busy;
  logic          done;
  logic          err_underrun;
  logic          err_len;

  cfg_loader dut (
    .clk           (clk),
    .crst          (crst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_id        (cmd_id),
    .cmd_len       (cmd_len),
    .dat_valid     (dat_valid),
    .dat_ready     (dat_ready),
    .dat           (dat),
    .cfg_out_start (cfg_out_start),
    .cfg_bit_out   (cfg_bit_out),
    .busy          (busy),
    .done          (done),
    .err_underrun  (err_underrun),
    .err_len       (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w;
    int           cyc;
  } ent_t;

  typedef struct {
    logic [2:0]  id;
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          late_slot;
    int          late_by;
    logic [63:0] exp_cap;
    int          exp_words;
    logic        exp_ur;
    logic        exp_par;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] wsrc [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: header bits, then payload bit p taken from the
  // oldest buffered word (usable two cycles after its
  // handshake), zero if none; word retired after its last bit.
  task automatic run_frame(input logic [2:0] id,
                           input int len,
                           input int late_slot,
                           input int late_by,
                           input int pct,
                           output logic [63:0] cap,
                           output int hs,
                           output logic urf,
                           output logic parf);
    int   n;
    int   tot;
    int   k;
    int   p;
    int   j;
    ent_t mq [$];
    ent_t e;
    logic ur;
    logic par;
    logic eb;
    logic edr;
    logic have;
    logic ok;
    n   = (len + W - 1) / W;
    tot = ID + len + PB;
    k   = 0;
    ur  = 1'b0;
    par = 1'b0;
    cap = '0;
    hs  = 0;
    parf = 1'b0;
    chk("cmd_ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_len   = 16'(len);
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < tot + GAP; c++) begin
      eb = 1'b0;
      if (c < ID) begin
        eb = id[ID-1-c];
      end else if (c < ID + len) begin
        p = c - ID;
        j = p % W;
        have = mq.size() > 0 && mq[0].cyc <= c - 2;
        eb = have ? mq[0].w[j] : 1'b0;
        if (!have) ur = 1'b1;
        par = par ^ eb;
        if (p < 64) cap[p] = eb;
        if (j == W - 1 && have) void'(mq.pop_front());
      end else if (c == ID + len && PB == 1) begin
        eb = par;
        parf = cfg_bit_out;
      end
      edr = c < ID + len && k < n && mq.size() < 2;
      chk("start", cfg_out_start, c == 0);
      chk("bit", cfg_bit_out, eb);
      chk("busy", busy, 1);
      chk("done", done, c == tot + GAP - 1);
      chk("cmd_ready", cmd_ready, 0);
      chk("dat_ready", dat_ready, edr);
      chk("err_underrun", err_underrun, ur);
      chk("err_len", err_len, 0);
      ok = k < n
        && !(k == late_slot
             && c < ID + late_slot * W + late_by)
        && $urandom_range(0, 99) < pct;
      dat_valid = ok;
      dat = ok ? wsrc[k] : $urandom;
      if (dat_valid && dat_ready) hs++;
      if (ok && edr) begin
        e.w   = wsrc[k];
        e.cyc = c;
        mq.push_back(e);
        k++;
      end
      step();
    end
    dat_valid = 1'b0;
    chk("busy_end", busy, 0);
    chk("cmd_ready_end", cmd_ready, 1);
    chk("done_end", done, 0);
    chk("ur_sticky", err_underrun, ur);
    urf = ur;
  endtask

  initial begin
    vec_t        vt [10];
    logic [63:0] cap;
    int          hs;
    logic        urf;
    logic        parf;
    int          len;
    int          n;

    vt[0] = '{3'b101, 8, 32'hA5, 32'h0, -1, 0,
              64'hA5, 1, 1'b0, 1'b0};
    vt[1] = '{3'b010, 40, 32'hFFFFFFFF, 32'h3, -1, 0,
              64'h03_FFFFFFFF, 2, 1'b0, 1'b0};
    vt[2] = '{3'b110, 64, 32'h12345678, 32'hDEADBEEF,
              1, 10, 64'hDEADB000_12345678, 2,
              1'b1, 1'b1};
    vt[3] = '{3'b000, 3, 32'h6, 32'h0, -1, 0,
              64'h6, 1, 1'b0, 1'b0};
    vt[4] = '{3'b111, 33, 32'h0, 32'h1, -1, 0,
              64'h1_00000000, 2, 1'b0, 1'b1};
    vt[5] = '{3'b001, 32, 32'h80000001, 32'h0, -1, 0,
              64'h80000001, 1, 1'b0, 1'b0};
    vt[6] = '{3'b011, 8, 32'h7, 32'h0, -1, 0,
              64'h7, 1, 1'b0, 1'b1};
    vt[7] = '{3'b100, 8, 32'h3, 32'h0, -1, 0,
              64'h3, 1, 1'b0, 1'b0};
    vt[8] = '{3'b101, 8, 32'hFF, 32'h0, 0, 2,
              64'hF0, 1, 1'b1, 1'b0};
    vt[9] = '{3'b010, 1, 32'h1, 32'h0, -1, 0,
              64'h1, 1, 1'b0, 1'b1};

    crst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_id    = '0;
    cmd_len   = '0;
    dat_valid = 1'b0;
    dat       = '0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", cfg_out_start, 0);
    chk("rst_bit", cfg_bit_out, 0);
    step();
    step();
    crst = 1'b0;
    chk("rel_cmd_ready0", cmd_ready, 0);
    step();
    chk("rel_cmd_ready1", cmd_ready, 1);
    chk("rel_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      wsrc.delete();
      wsrc.push_back(vt[i].w0);
      wsrc.push_back(vt[i].w1);
      run_frame(vt[i].id, vt[i].len, vt[i].late_slot,
                vt[i].late_by, 100, cap, hs, urf, parf);
      chk($sformatf("v%0d_payload", i), cap,
          vt[i].exp_cap);
      chk($sformatf("v%0d_words", i), hs,
          vt[i].exp_words);
      chk($sformatf("v%0d_underrun", i), urf,
          vt[i].exp_ur);
`ifdef CFG_LOADER_PARITY_EN
      chk($sformatf("v%0d_parity", i), parf,
          vt[i].exp_par);
`endif
    end

    cmd_valid = 1'b1;
    cmd_len   = '0;
    cmd_id    = 3'b011;
    chk("zl_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    dat_valid = 1'b1;
    chk("zl_err_len", err_len, 1);
    chk("zl_start", cfg_out_start, 0);
    chk("zl_busy", busy, 0);
    chk("zl_dat_ready", dat_ready, 0);
    chk("zl_cmd_ready", cmd_ready, 1);
    chk("zl_ur_clr", err_underrun, 0);
    step();
    chk("zl_err_len_off", err_len, 0);
    chk("zl_start2", cfg_out_start, 0);
    chk("zl_dat_ready2", dat_ready, 0);
    dat_valid = 1'b0;
    step();

    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 100);
      n = (len + W - 1) / W;
      wsrc.delete();
      for (int q = 0; q < n; q++) wsrc.push_back($urandom);
      run_frame(3'($urandom), len, -1, 0,
                $urandom_range(25, 100), cap, hs, urf, parf);
    end

    cmd_valid = 1'b1;
    cmd_id    = 3'b111;
    cmd_len   = 16'd40;
    step();
    cmd_valid = 1'b0;
    dat_valid = 1'b1;
    dat       = 32'hFFFFFFFF;
    for (int c = 0; c < ID + 5; c++) step();
    chk("mid_bit", cfg_bit_out, 1);
    chk("mid_busy", busy, 1);
    #2;
    crst = 1'b1;
    #1;
    chk("arst_start", cfg_out_start, 0);
    chk("arst_bit", cfg_bit_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dat_ready", dat_ready, 0);
    dat_valid = 1'b0;
    step();
    chk("arst_done2", done, 0);
    step();
    crst = 1'b0;
    chk("arst_cmd_ready0", cmd_ready, 0);
    step();
    chk("arst_cmd_ready1", cmd_ready, 1);
    chk("arst_done3", done, 0);
    chk("arst_ur", err_underrun, 0);

    wsrc.delete();
    wsrc.push_back(vt[0].w0);
    run_frame(vt[0].id, vt[0].len, -1, 0, 100,
              cap, hs, urf, parf);
    chk("post_rst_payload", cap, vt[0].exp_cap);
    chk("post_rst_words", hs, vt[0].exp_words);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration-chain driver that sits directly upstream of the first tile's config port.
- Accepts a parallel command (target ID, payload bit count) plus a stream of payload words over valid/ready handshakes.
- Serializes them into one chain frame on cfg_out_start/cfg_bit_out, which connect to the cfg_in_start/cfg_bit_in of the first switch box or CLB.
- Guarantees exact frame length so downstream shift registers stay aligned, even on data underrun.

Parameters:
- WORD_WIDTH, 32, payload word width on the data port.
- ID_WIDTH, 3, target ID field width; must match downstream config blocks.
- LEN_WIDTH, 16, width of the payload bit count.
- GAP_CYCLES, 2, idle cycles after each frame, with chain outputs low, before the next command is accepted.

Ports:
- clk  in  1  clock.
- crst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  loader can accept a command.
- cmd_id  in  ID_WIDTH  target block ID.
- cmd_len  in  LEN_WIDTH  payload bits to shift.
- dat_valid  in  1  payload word present.
- dat_ready  out  1  loader accepts the word this cycle.
- dat  in  WORD_WIDTH  payload word, shifted LSB first.
- cfg_out_start  out  1  frame start strobe to chain.
- cfg_bit_out  out  1  serial chain data.
- busy  out  1  frame in progress (any state but IDLE).
- done  out  1  one-cycle pulse at frame completion.
- err_underrun  out  1  sticky; set on payload underrun, cleared by the next command accept.
- err_len  out  1  one-cycle pulse on a zero-length command.

Behaviour:
- Reset (async, crst=1): FSM to IDLE, both word buffers invalid, counters 0, all outputs 0 except cmd_ready=0. cmd_ready goes to 1 on the first clock edge after crst deasserts.
- Reset mid-frame: frame is abandoned immediately with no done pulse; chain outputs drop to 0 asynchronously.
- cmd_ready=1 only in IDLE. A command is accepted on a cycle with cmd_valid&cmd_ready (cycle T); cmd_id and cmd_len are latched.
- cmd_len==0: err_len pulses at T+1, no frame is emitted, FSM stays IDLE, done is not pulsed.
- States: IDLE -> HDR -> PAY -> [PAR] -> GAP -> IDLE.
- HDR:
  - Runs T+1 .. T+ID_WIDTH.
  - cfg_bit_out = cmd_id, MSB first.
  - cfg_out_start=1 only at T+1.
- PAY:
  - Runs exactly cmd_len cycles following HDR, one bit per cycle, LSB of each word first.
  - Words consumed = ceil(cmd_len/WORD_WIDTH); unused upper bits of the last word are discarded.
  - Two-entry word buffer. dat_ready=1 whenever a buffer entry is free and words remain to fetch; fetching starts at T+1, so words are prefetched during HDR.
  - Underrun: if the next word is needed and no buffer entry is valid, shift 0 for that word's bits and set err_underrun. Frame length is unchanged. Any late-arriving word is still consumed, and its bits replace the remaining zeros from the next bit boundary.
  - Total words consumed per frame never exceeds ceil(cmd_len/WORD_WIDTH).
- GAP: cfg_out_start=0 and cfg_bit_out=0 for GAP_CYCLES cycles. done pulses in the last GAP cycle, and the FSM returns to IDLE the next cycle.
- Counters: bit counter is LEN_WIDTH wide and counts down to 1 without wrap. cmd_len = 2^LEN_WIDTH-1 is legal.
- cfg_out_start and cfg_bit_out are registered outputs; no combinational path from any input.
- Back-to-back: with cmd_valid held high, the next accept occurs on the first IDLE cycle after done.

Optional Feature:
- Macro CFG_LOADER_PARITY_EN.
- Defined: state PAR inserts one extra bit after PAY, equal to the XOR of all cmd_len payload bits actually shifted (zeros included on underrun). Frame length = ID_WIDTH + cmd_len + 1.
- Undefined: PAR state is absent. Frame length = ID_WIDTH + cmd_len.

Test Plan:
- Reset: crst pulse mid-PAY -> cfg_out_start=0, cfg_bit_out=0, busy=0 asynchronously; no done; cmd_ready=1 one edge after release.
- Basic frame: cmd_id=3'b101, cmd_len=8, dat=32'h000000A5 ready early -> start high 1 cycle; serial stream 1,0,1 then 1,0,1,0,0,1,0,1; exactly one word consumed; done 2 cycles after the last bit.
- Multi-word: cmd_len=40, two words 32'hFFFFFFFF, 32'h00000003 -> 32 ones then 1,1,0,0,0,0,0,0; upper 24 bits of word 2 dropped; exactly 2 dat handshakes.
- Underrun: cmd_len=64 with word 2 withheld until 10 cycles into its slot -> zeros for those bits, err_underrun=1, frame still 3+64 bits; err_underrun cleared on the next accept.
- Zero length: cmd_len=0 -> err_len pulse at T+1, no start strobe, no dat handshake, cmd_ready back to 1.
- Parity (CFG_LOADER_PARITY_EN): cmd_len=8, dat=8'h07 -> extra bit 1 after payload; dat=8'h03 -> extra bit 0.
